spart_driver: RTL and testbench

Bus-master state machine that sits directly upstream of the SPART on its processor-side register bus. After reset it programs the SPART baud-rate divisor from the board switches, then runs an echo loop: every byte the SPART receives is read out of its RX queue and written back into its TX queue. It reprograms the divisor whenever the switch setting changes, and counts echoed bytes for debug LEDs.

---
 rtl/spart_pkg.sv | 34 +++
 rtl/spart_driver_sync2.sv | 25 ++
 rtl/spart_driver.sv | 123 ++++++++++++
 tb/tb_spart_driver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master driver: FSM states,
// SPART register addresses and the baud-rate divisor lookup.
package spart_pkg;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        WAIT,
        READ,
        WRITE
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Divisor = clk / baud. Every branch divides constants, so the
    // result folds into a four-entry table for a fixed clk_hz.
    function automatic logic [12:0] divisor(
        input int         clk_hz,
        input logic [1:0] cfg
    );
        logic [12:0] d;
        case (cfg)
            2'b00:   d = 13'(clk_hz / 9600);
            2'b01:   d = 13'(clk_hz / 19200);
            2'b10:   d = 13'(clk_hz / 38400);
            default: d = 13'(clk_hz / 115200);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spart_driver_sync2.sv
// Two-flop synchronizer, 2 bits wide, synchronous active-high reset to 0.
// Ports: clk, rst, i_d (async input), o_q (synchronized output).
module sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_d,
    output logic [1:0] o_q
);

    logic [1:0] r_meta;
    logic [1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from br_cfg, then echoes
// every received byte back. Ports: clk, rst, br_cfg, SPART bus
// (iocs_n, iorw_n, ioaddr, databus), tx_q_full, rx_q_empty, echo_cnt.
module spart_driver
    import spart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs_n,
    output logic       iorw_n,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_q_full,
    input  logic       rx_q_empty,
    output logic [7:0] echo_cnt
);

    state_t      r_state;
    logic [1:0]  r_cfg_q;
    logic [7:0]  r_hold;
    logic [7:0]  r_echo_cnt;
    logic [1:0]  w_cfg_sync;
    logic [12:0] w_div_new;
    logic [12:0] w_div_cur;
    logic        w_cs;
    logic        w_rd;
    logic [1:0]  w_addr;
    logic [7:0]  w_wdata;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (br_cfg),
        .o_q (w_cfg_sync)
    );

    // Low byte uses the setting being latched; high byte uses the
    // latched copy so both halves always belong to one divisor.
    assign w_div_new = divisor(CLK_HZ, w_cfg_sync);
    assign w_div_cur = divisor(CLK_HZ, r_cfg_q);

    // Moore bus decode; the bus is forced idle while reset is held.
    always_comb begin
        w_cs    = 1'b0;
        w_rd    = 1'b1;
        w_addr  = ADDR_BUF;
        w_wdata = 8'h00;
        case (r_state)
            CFG_LO: begin
                w_cs    = 1'b1;
                w_rd    = 1'b0;
                w_addr  = ADDR_DBL;
                w_wdata = w_div_new[7:0];
            end
            CFG_HI: begin
                w_cs    = 1'b1;
                w_rd    = 1'b0;
                w_addr  = ADDR_DBH;
                w_wdata = {3'b000, w_div_cur[12:8]};
            end
            READ: begin
                w_cs   = 1'b1;
                w_addr = ADDR_BUF;
            end
            WRITE: begin
                w_cs    = 1'b1;
                w_rd    = 1'b0;
                w_addr  = ADDR_BUF;
                w_wdata = r_hold;
            end
            default: ;
        endcase
        if (rst) begin
            w_cs   = 1'b0;
            w_rd   = 1'b1;
            w_addr = ADDR_BUF;
        end
    end

    assign iocs_n   = ~w_cs;
    assign iorw_n   = w_rd;
    assign ioaddr   = w_addr;
    assign echo_cnt = r_echo_cnt;
    assign databus  = (!iocs_n && !iorw_n) ? w_wdata : 8'hzz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CFG_LO;
            r_cfg_q    <= 2'b00;
            r_hold     <= 8'h00;
            r_echo_cnt <= 8'h00;
        end else begin
            unique case (r_state)
                CFG_LO: begin
                    r_cfg_q <= w_cfg_sync;
                    r_state <= CFG_HI;
                end
                CFG_HI: r_state <= WAIT;
                // Reprogramming outranks echoing; a switch change that
                // lands mid-echo is only seen once back here.
                WAIT: begin
                    if (w_cfg_sync != r_cfg_q)
                        r_state <= CFG_LO;
                    else if (!rx_q_empty && !tx_q_full)
                        r_state <= READ;
                end
                READ: begin
                    r_hold  <= databus;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_echo_cnt <= r_echo_cnt + 8'd1;
                    r_state    <= WAIT;
                end
                default: r_state <= CFG_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: a SPART model feeds RX bytes and
// checks every bus write against queued expectations.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b00;
    logic       tx_q_full = 1'b0;
    logic       rx_q_empty = 1'b1;
    wire        iocs_n;
    wire        iorw_n;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    wire  [7:0] echo_cnt;
    logic [7:0] rd_data = 8'h00;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [9:0] cfg_exp[$];

    int vecs = 0;
    int miss = 0;
    int n_echo = 0;
    bit prev_idle = 1'b1;
    bit prev_rd = 1'b0;
    bit prev_txf = 1'b0;

    spart_driver #(.CLK_HZ(50_000_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .iocs_n     (iocs_n),
        .iorw_n     (iorw_n),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .tx_q_full  (tx_q_full),
        .rx_q_empty (rx_q_empty),
        .echo_cnt   (echo_cnt)
    );

    assign databus = (!iocs_n && iorw_n) ? rd_data : 8'hzz;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int baud_of(input logic [1:0] c);
        case (c)
            2'b00:   return 9600;
            2'b01:   return 19200;
            2'b10:   return 38400;
            default: return 115200;
        endcase
    endfunction

    task automatic push_cfg(input logic [1:0] c);
        int d;
        d = 50_000_000 / baud_of(c);
        cfg_exp.push_back({2'b10, 8'(d & 255)});
        cfg_exp.push_back({2'b11, 8'((d >> 8) & 255)});
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_q.push_back(b);
        exp_q.push_back(b);
        n_echo++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (exp_q.size() == 0 && rx_q.size() == 0 &&
                cfg_exp.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
        repeat (2) cyc();
    endtask

    task automatic wait_read();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (!iocs_n && iorw_n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("read_seen", seen, 1);
    endtask

    // SPART model and monitor; bus is stable at the falling edge.
    always @(negedge clk) begin
        if (iocs_n) begin
            chk("bus_z", databus === 8'hzz, 1);
        end else if (iorw_n) begin
            chk("rd_addr", ioaddr, 0);
            chk("rd_after_wait", prev_idle, 1);
            chk("rd_txfull", prev_txf, 0);
            chk("rd_nonempty", rx_q.size() > 0, 1);
            if (rx_q.size() > 0)
                rd_data = rx_q.pop_front();
        end else begin
            chk("wr_not_stat", ioaddr != 2'b01, 1);
            if (ioaddr == 2'b00) begin
                chk("wr_after_rd", prev_rd, 1);
                chk("echo_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("echo_data", databus, exp_q.pop_front());
            end else if (ioaddr[1]) begin
                chk("cfg_pending", cfg_exp.size() > 0, 1);
                if (cfg_exp.size() > 0)
                    chk("cfg_write", {ioaddr, databus},
                        cfg_exp.pop_front());
            end
        end
        prev_idle  = iocs_n;
        prev_rd    = !iocs_n && iorw_n;
        prev_txf   = tx_q_full;
        rx_q_empty = (rx_q.size() == 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] nc;
        int k;
        // Reset state and initial 9600 programming.
        repeat (3) cyc();
        chk("rst_cs", iocs_n, 1);
        chk("rst_rw", iorw_n, 1);
        chk("rst_addr", ioaddr, 0);
        chk("rst_cnt", echo_cnt, 0);
        push_cfg(2'b00);
        rst = 1'b0;
        #1;
        chk("cyc0_dbl", {iocs_n, iorw_n, ioaddr}, 4'b0010);
        drain();

        // Two-byte echo.
        push_byte(8'h41);
        push_byte(8'h42);
        drain();
        chk("cnt_two", echo_cnt, 2);
        chk("rx_empty", rx_q_empty, 1);

        // Backpressure: no read while TX is full.
        tx_q_full = 1'b1;
        push_byte(8'($urandom));
        repeat (20) cyc();
        chk("txf_rx_held", rx_q.size(), 1);
        chk("txf_no_echo", exp_q.size(), 1);
        tx_q_full = 1'b0;
        drain();
        chk("cnt_three", echo_cnt, 3);

        // Switch change during READ is deferred past WRITE.
        push_byte(8'($urandom));
        wait_read();
        br_cfg = 2'b10;
        push_cfg(2'b10);
        cyc();
        chk("wr_before_cfg", {iocs_n, iorw_n, ioaddr}, 4'b0000);
        drain();

        // Reset with switches at 115200.
        rst = 1'b1;
        br_cfg = 2'b11;
        repeat (3) cyc();
        rx_q.delete();
        exp_q.delete();
        cfg_exp.delete();
        n_echo = 0;
        chk("rst2_cnt", echo_cnt, 0);
        push_cfg(2'b00);
        push_cfg(2'b11);
        rst = 1'b0;
        drain();
        repeat (30) cyc();
        chk("no_reprog", cfg_exp.size(), 0);

        // Randomized traffic with backpressure and switch changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0)
                push_byte(8'($urandom));
            tx_q_full = ($urandom_range(0, 3) == 0);
            if (cfg_exp.size() == 0 && $urandom_range(0, 59) == 0) begin
                nc = 2'($urandom_range(0, 3));
                if (nc != br_cfg) begin
                    br_cfg = nc;
                    push_cfg(nc);
                end
            end
            cyc();
        end
        tx_q_full = 1'b0;
        drain();
        chk("cnt_rand", echo_cnt, n_echo % 256);

        // Fill up to a multiple of 256 to force the wrap.
        k = 256 - (n_echo % 256);
        for (int i = 0; i < k; i++)
            push_byte(8'($urandom));
        drain();
        chk("cnt_wrap", echo_cnt, n_echo % 256);
        chk("cnt_wrap_zero", echo_cnt, 0);

        // Reset between READ and WRITE.
        push_byte(8'h5a);
        push_byte(8'ha5);
        wait_read();
        rst = 1'b1;
        cyc();
        rx_q.delete();
        exp_q.delete();
        cfg_exp.delete();
        n_echo = 0;
        cyc();
        chk("rst_mid_cnt", echo_cnt, 0);
        push_cfg(2'b00);
        push_cfg(br_cfg);
        rst = 1'b0;
        drain();
        chk("rst_mid_cnt2", echo_cnt, 0);
        push_byte(8'h7e);
        drain();
        chk("post_rst_cnt", echo_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miss);
        $finish;
    end

endmodule
